// File: rtl/store_queue.sv
// rtl/store_queue.sv - store buffer: formats SB/SH/SW into word writes with strobes, drains in order, flags load hazards
module store_queue #(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        st_valid,
  output logic        st_ready,
  input  logic [2:0]  store_type,
  input  logic [31:0] st_addr,
  input  logic [31:0] st_data,
  output logic        st_misaligned,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic        mem_ack,
  input  logic [31:0] ld_addr,
  output logic        ld_hazard,
  output logic        empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

  logic [29:0]      q_addr [DEPTH];
  logic [31:0]      q_data [DEPTH];
  logic [3:0]       q_strb [DEPTH];
  logic [DEPTH-1:0] q_valid;
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;

  logic        fmt_ok;
  logic [31:0] fmt_data;
  logic [3:0]  fmt_strb;
  logic        accept;
  logic        push;
  logic        pop;
  logic        ld_lsb_unused;

  assign st_ready      = (count != FULL_CNT);
  assign empty         = (count == '0);
  assign mem_we        = !empty;
  assign mem_addr      = {q_addr[rd_ptr], 2'b00};
  assign mem_wdata     = q_data[rd_ptr];
  assign mem_wstrb     = q_strb[rd_ptr];
  assign accept        = st_valid && st_ready;
  assign push          = accept && fmt_ok;
  assign pop           = mem_ack && mem_we;
  assign ld_lsb_unused = ^ld_addr[1:0];

  // Lane replication means memory can take the strobed bytes straight from wdata.
  always_comb begin
    fmt_ok   = 1'b0;
    fmt_data = st_data;
    fmt_strb = 4'b0000;
    case (store_type)
      3'b000: begin
        fmt_ok   = 1'b1;
        fmt_data = {4{st_data[7:0]}};
        fmt_strb = 4'b0001 << st_addr[1:0];
      end
      3'b001: begin
        fmt_ok   = !st_addr[0];
        fmt_data = {2{st_data[15:0]}};
        fmt_strb = st_addr[1] ? 4'b1100 : 4'b0011;
      end
      3'b010: begin
        fmt_ok   = (st_addr[1:0] == 2'b00);
        fmt_data = st_data;
        fmt_strb = 4'b1111;
      end
      default: fmt_ok = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      count         <= '0;
      q_valid       <= '0;
      st_misaligned <= 1'b0;
    end else begin
      st_misaligned <= accept && !fmt_ok;
      if (push) begin
        q_valid[wr_ptr] <= 1'b1;
        wr_ptr          <= wr_ptr + 1'b1;
      end
      if (pop) begin
        q_valid[rd_ptr] <= 1'b0;
        rd_ptr          <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Entry payload needs no reset; q_valid alone decides what is live.
  always_ff @(posedge clk) begin
    if (push) begin
      q_addr[wr_ptr] <= st_addr[31:2];
      q_data[wr_ptr] <= fmt_data;
      q_strb[wr_ptr] <= fmt_strb;
    end
  end

  // Word-granular and strobe-blind on purpose: a false stall is cheap, a missed one is not.
  always_comb begin
    ld_hazard = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (q_valid[AW'(i)] && (q_addr[i] == ld_addr[31:2])) ld_hazard = 1'b1;
    end
  end

endmodule

// File: tb/tb_store_queue.sv
// tb/tb_store_queue.sv - randomized and directed bench for store_queue against a queue-based model
module tb_store_queue;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        st_valid;
  logic        st_ready;
  logic [2:0]  store_type;
  logic [31:0] st_addr;
  logic [31:0] st_data;
  logic        st_misaligned;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_ack;
  logic [31:0] ld_addr;
  logic        ld_hazard;
  logic        empty;

  store_queue #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .st_valid(st_valid), .st_ready(st_ready),
    .store_type(store_type), .st_addr(st_addr), .st_data(st_data),
    .st_misaligned(st_misaligned), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .mem_ack(mem_ack),
    .ld_addr(ld_addr), .ld_hazard(ld_hazard), .empty(empty)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [29:0] word;
    logic [31:0] data;
    logic [3:0]  strb;
  } ent_t;

  ent_t q[$];
  bit   mis_m  = 0;
  bit   armed  = 0;
  int   total  = 0;
  int   bad    = 0;
  int   writes = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // A store of 2**type bytes: legal if naturally aligned; byte lane b carries data byte (b mod size).
  function automatic void fmt(input logic [2:0] t, input logic [31:0] a, input logic [31:0] d,
                              output bit ok, output ent_t e);
    int size;
    int lane;
    e.word = a[31:2];
    e.data = '0;
    e.strb = '0;
    ok = 0;
    if (t > 3'd2) return;
    size = 1 << t;
    lane = int'(a[1:0]);
    ok = (lane % size) == 0;
    for (int b = 0; b < 4; b++) begin
      e.data[8*b +: 8] = d[8*(b % size) +: 8];
      e.strb[b]        = (b >= lane) && (b < lane + size);
    end
  endfunction

  function automatic bit hz(input logic [31:0] la);
    foreach (q[i]) if (q[i].word == la[31:2]) return 1;
    return 0;
  endfunction

  always @(posedge clk) begin
    bit   acc;
    bit   pop;
    bit   ok;
    ent_t e;
    if (rst) begin
      q.delete();
      mis_m = 0;
      armed = 1;
    end else begin
      if (mem_we && mem_ack) writes++;
      acc = st_valid && (q.size() < DEPTH);
      pop = mem_ack && (q.size() > 0);
      fmt(store_type, st_addr, st_data, ok, e);
      if (pop) void'(q.pop_front());
      if (acc && ok) q.push_back(e);
      mis_m = acc && !ok;
    end
  end

  always @(negedge clk) begin
    if (armed) begin
      chk("st_ready", st_ready, q.size() < DEPTH);
      chk("empty", empty, q.size() == 0);
      chk("mem_we", mem_we, q.size() != 0);
      chk("st_misaligned", st_misaligned, mis_m);
      chk("ld_hazard", ld_hazard, hz(ld_addr));
      if (q.size() != 0) begin
        chk("mem_addr", mem_addr, {q[0].word, 2'b00});
        chk("mem_wdata", mem_wdata, q[0].data);
        chk("mem_wstrb", mem_wstrb, 32'(q[0].strb));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [2:0] t, input logic [31:0] a, input logic [31:0] d);
    st_valid   = v;
    store_type = t;
    st_addr    = a;
    st_data    = d;
  endtask

  int w0;

  initial begin
    rst = 1; mem_ack = 0; ld_addr = 0;
    drive(0, 3'd0, 0, 0);
    step(); step();
    rst = 0;
    mid();
    chk("reset_ready", st_ready, 1);
    chk("reset_empty", empty, 1);
    chk("reset_we", mem_we, 0);
    chk("reset_hazard", ld_hazard, 0);

    // SB to top byte lane
    step(); drive(1, 3'd0, 32'h1003, 32'h0000_00AB);
    step(); drive(0, 3'd0, 0, 0); ld_addr = 32'h1001;
    mid();
    chk("sb_we", mem_we, 1);
    chk("sb_addr", mem_addr, 32'h1000);
    chk("sb_wdata", mem_wdata, 32'hABABABAB);
    chk("sb_wstrb", mem_wstrb, 32'h8);
    chk("sb_hazard", ld_hazard, 1);
    step(); mem_ack = 1;
    step(); mem_ack = 0;
    mid();
    chk("sb_empty_after_ack", empty, 1);
    chk("sb_hazard_drop", ld_hazard, 0);

    // SH then SW back to back with ack held
    step(); mem_ack = 1; drive(1, 3'd1, 32'h2002, 32'h1234CAFE);
    step(); drive(1, 3'd2, 32'h3000, 32'hDEADBEEF);
    mid();
    chk("sh_addr", mem_addr, 32'h2000);
    chk("sh_wdata", mem_wdata, 32'hCAFECAFE);
    chk("sh_wstrb", mem_wstrb, 32'hC);
    step(); drive(0, 3'd0, 0, 0);
    mid();
    chk("sw_addr", mem_addr, 32'h3000);
    chk("sw_wdata", mem_wdata, 32'hDEADBEEF);
    chk("sw_wstrb", mem_wstrb, 32'hF);
    step(); mem_ack = 0;
    mid();
    chk("shsw_empty", empty, 1);

    // misaligned and invalid-type requests
    step(); drive(1, 3'd2, 32'h4002, 32'h1);
    step(); drive(1, 3'd1, 32'h4001, 32'h2);
    mid(); chk("mis_sw", st_misaligned, 1); chk("mis_sw_we", mem_we, 0);
    step(); drive(1, 3'd7, 32'h4000, 32'h3);
    mid(); chk("mis_sh", st_misaligned, 1);
    step(); drive(0, 3'd0, 0, 0);
    mid(); chk("mis_type", st_misaligned, 1);
    step();
    mid(); chk("mis_clear", st_misaligned, 0); chk("mis_empty", empty, 1);

    // fill to full, hold fifth request until space frees
    w0 = writes;
    for (int i = 0; i < 4; i++) begin
      step(); drive(1, 3'd2, 32'h5000 + 32'(4*i), 32'h1111_0000 + 32'(i));
    end
    step(); drive(1, 3'd2, 32'h5010, 32'h1111_0004);
    mid(); chk("full_ready", st_ready, 0);
    step(); step();
    mid(); chk("full_hold_ready", st_ready, 0);
    step(); mem_ack = 1;
    step(); mem_ack = 0;
    mid(); chk("after_pop_ready", st_ready, 1); chk("head_second", mem_wdata, 32'h1111_0001);
    step(); drive(0, 3'd0, 0, 0);
    mid(); chk("refull_ready", st_ready, 0);
    mem_ack = 1;
    for (int i = 0; i < 5; i++) step();
    mem_ack = 0;
    mid();
    chk("fill_writes", 32'(writes - w0), 32'd5);
    chk("fill_empty", empty, 1);

    // count at DEPTH-1 with simultaneous accept and pop
    for (int i = 0; i < 3; i++) begin
      step(); drive(1, 3'd0, 32'h6000 + 32'(i), 32'h0000_00A0 + 32'(i));
    end
    step(); drive(1, 3'd1, 32'h6100, 32'h0000_BEEF); mem_ack = 1;
    step(); drive(0, 3'd0, 0, 0); mem_ack = 0;
    mid();
    chk("cnt3_ready", st_ready, 1);
    chk("cnt3_head_data", mem_wdata, 32'hA1A1A1A1);
    chk("cnt3_head_strb", mem_wstrb, 32'h2);
    mem_ack = 1;
    for (int i = 0; i < 3; i++) step();
    mem_ack = 0;
    mid(); chk("cnt3_empty", empty, 1);

    // reset mid-drain
    step(); drive(1, 3'd2, 32'h7000, 32'h7);
    step(); drive(1, 3'd2, 32'h7004, 32'h8);
    step(); drive(0, 3'd0, 0, 0); rst = 1;
    step(); rst = 0;
    mid();
    chk("rst_we", mem_we, 0);
    chk("rst_empty", empty, 1);
    chk("rst_ready", st_ready, 1);

    // randomized traffic over a small address window so hazards occur
    for (int n = 0; n < 4000; n++) begin
      step();
      rst      = ($urandom_range(0, 199) == 0);
      st_valid = ($urandom_range(0, 2) != 0);
      store_type = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(3, 7)) : 3'($urandom_range(0, 2));
      st_addr  = 32'h8000 + 32'($urandom_range(0, 31));
      st_data  = $urandom;
      mem_ack  = ($urandom_range(0, 2) != 0);
      ld_addr  = 32'h8000 + 32'($urandom_range(0, 31));
    end
    step();
    rst = 0; st_valid = 0; mem_ack = 0;
    step(); step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/store_queue.md
# store_queue

Write-side counterpart of the load datapath: accepts SB/SH/SW requests from the MEM stage, converts each into a word-aligned memory write with replicated data and byte strobes, and buffers them in a small FIFO drained to data memory over a req/ack handshake. Also flags load/store address hazards so the MEM stage can stall a load that would read a word with a pending store.

## Interface
- DEPTH, 4, number of buffered stores; power of two, ≥2
- clk  input  1  clock, all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- st_valid  input  1  store request valid
- st_ready  output  1  queue can accept; equals !full
- store_type  input  3  000 SB, 001 SH, 010 SW; all other codes invalid
- st_addr  input  32  byte address of store
- st_data  input  32  store data, right-justified
- st_misaligned  output  1  one-cycle pulse: previous accepted request was misaligned or had invalid type
- mem_we  output  1  write request to data memory; high whenever queue non-empty
- mem_addr  output  32  {head_addr[31:2], 2'b00}
- mem_wdata  output  32  lane-replicated write data of head entry
- mem_wstrb  output  4  byte enables of head entry, bit i = byte lane i (little-endian)
- mem_ack  input  1  memory accepted the current write
- ld_addr  input  32  address of load in MEM stage
- ld_hazard  output  1  a queued store targets word ld_addr[31:2]
- empty  output  1  no stores pending (used for fence/drain)

## Operation
- Acceptance: request accepted on an edge where st_valid && st_ready.
- Alignment check on accept: SB any address; SH requires st_addr[0]==0; SW requires st_addr[1:0]==0. Invalid type or misaligned: request consumed, not enqueued, st_misaligned=1 the following cycle only.
- Formatting at enqueue (stored per entry: addr[31:2], wdata, wstrb):
  - SB: wdata={4{st_data[7:0]}}, wstrb=4'b0001<<st_addr[1:0]
  - SH: wdata={2{st_data[15:0]}}, wstrb= st_addr[1] ? 4'b1100 : 4'b0011
  - SW: wdata=st_data, wstrb=4'b1111
- FIFO: write pointer, read pointer, count (log2(DEPTH)+1 bits). Pointers wrap modulo DEPTH. full = count==DEPTH; empty = count==0.
- Drain: mem_we = !empty; mem_addr/mem_wdata/mem_wstrb driven from head entry and held stable until the cycle mem_ack is high. On mem_ack && mem_we, head pops at that edge; next entry presented the following cycle with mem_we still high. mem_ack while !mem_we ignored.
- Simultaneous enqueue and pop: count unchanged, both pointers advance. Accepted when not full, including count==DEPTH-1 with pop.
- Full: st_ready=0 regardless of mem_ack in same cycle (no combinational ready from ack).
- Hazard: ld_hazard = OR over valid entries of (entry.addr[31:2]==ld_addr[31:2]); combinational, stores with wstrb not overlapping the load still flag (conservative). Request being accepted in the current cycle is not included.
- Order: stores issued to memory strictly in acceptance order.

## Timing
- Reset values: count=0, pointers=0, st_ready=1, mem_we=0, empty=1, ld_hazard=0, st_misaligned=0; entry contents don't-care. Reset mid-drain discards all pending stores; mem_we low the cycle after reset edge.
- Latency: store accepted at edge N into empty queue → mem_we=1 with its data during cycle N+1.
- Throughput: one store per cycle in and out when mem_ack held high.
- st_misaligned: registered, high exactly one cycle after offending accept edge; a valid store accepted the next cycle does not extend it.
- ld_hazard reacts same cycle to ld_addr and queue contents; drops the cycle after the matching entry pops.

## Test plan
- Reset then SB addr 0x1003 data 0xAB, mem_ack held 0 → next cycle mem_we=1, mem_addr=0x1000, mem_wdata=0xABABABAB, mem_wstrb=4'b1000; ld_addr=0x1001 gives ld_hazard=1; ack → empty=1 next cycle.
- SH addr 0x2002 data 0x1234CAFE and SW addr 0x3000 data 0xDEADBEEF, ack always 1 → writes in order: (0x2000, 0xCAFECAFE, 1100) then (0x3000, 0xDEADBEEF, 1111), one per cycle.
- SW addr 0x4002 and SH addr 0x4001 and store_type 3'b111 → each gives st_misaligned pulse one cycle, mem_we never rises, empty stays 1.
- Fill DEPTH=4 stores with ack=0 → st_ready=0 after 4th; 5th held request accepted only the cycle after first ack; total 5 writes emitted in order.
- Queue at count=3, simultaneous accept and ack → count stays 3, pointers wrap correctly, subsequent drain returns correct data.
- Two stores queued, assert rst during mem_we → next cycle mem_we=0, empty=1, st_ready=1; no further writes.
